// File: rtl/uart_pkg.sv
// Shared UART definitions: baud rate, receiver state encoding and bit timing.
package uart_pkg;

  localparam int unsigned UART_BAUD = 100000;

  typedef enum logic [2:0] {
    s_idle  = 3'd0,
    s_start = 3'd1,
    s_data  = 3'd2,
    s_stop  = 3'd3,
    s_break = 3'd4
  } uart_state_t;

  // Clocks per bit; shared so transmitter and receiver agree on timing.
  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz);
    return clk_hz / UART_BAUD;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid/frame_err pulses, break wait-out.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ);
  localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int unsigned COUNTER_WIDTH  = $clog2(CYCLES_PER_BIT);

  localparam logic [COUNTER_WIDTH-1:0] BIT_LAST  = COUNTER_WIDTH'(CYCLES_PER_BIT - 1);
  localparam logic [COUNTER_WIDTH-1:0] HALF_LAST = COUNTER_WIDTH'(HALF_BIT - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = COUNTER_WIDTH'(1);

  logic rx_s;

  uart_state_t              state,     state_d;
  logic [COUNTER_WIDTH-1:0] counter,   counter_d;
  logic [2:0]               bit_idx,   bit_idx_d;
  logic [7:0]               shift,     shift_d;
  logic [7:0]               data_d;
  logic                     valid_d;
  logic                     frame_err_d;
  logic                     busy_d;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (UART_RX),
    .q    (rx_s)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= s_idle;
      counter   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      counter   <= counter_d;
      bit_idx   <= bit_idx_d;
      shift     <= shift_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      busy      <= busy_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state;
    counter_d   = counter;
    bit_idx_d   = bit_idx;
    shift_d     = shift;
    data_d      = data;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state)
      s_idle: begin
        counter_d = '0;
        if (!rx_s) state_d = s_start;
      end

      // Confirm the start bit half a bit later so short glitches are rejected.
      s_start: begin
        counter_d = counter + CNT_ONE;
        if (counter == HALF_LAST) begin
          counter_d = '0;
          state_d   = rx_s ? s_idle : s_data;
        end
      end

      s_data: begin
        counter_d = counter + CNT_ONE;
        if (counter == BIT_LAST) begin
          counter_d = '0;
          shift_d   = {rx_s, shift[7:1]};
          if (bit_idx == 3'd7) begin
            bit_idx_d = '0;
            state_d   = s_stop;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end

      // Leaves for idle half a bit early so a following start edge is never missed.
      s_stop: begin
        counter_d = counter + CNT_ONE;
        if (counter == BIT_LAST) begin
          counter_d = '0;
          if (rx_s) begin
            data_d  = shift;
            valid_d = 1'b1;
            state_d = s_idle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = s_break;
          end
        end
      end

      s_break: begin
        counter_d = '0;
        if (rx_s) state_d = s_idle;
      end

      default: begin
        counter_d = '0;
        bit_idx_d = '0;
        state_d   = s_idle;
      end
    endcase

    busy_d = (state_d != s_idle);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are bit-banged from a bit-list model and results compared to expectations.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_line = 1'b1;
  logic       rx_line2 = 1'b1;
  logic [7:0] data, data2;
  logic       valid, valid2, frame_err, frame_err2, busy, busy2;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;

  logic [7:0] rx_q[$];
  int         rx_e[$];
  int         fe_cnt = 0;
  logic [7:0] rx2_q[$];
  int         rx2_e[$];
  int         fe2_cnt = 0;

  uart_rx dut (
    .clk      (clk),
    .reset    (reset),
    .UART_RX  (rx_line),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  uart_rx #(.CLK_HZ(2000000)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .UART_RX  (rx_line2),
    .data     (data2),
    .valid    (valid2),
    .frame_err(frame_err2),
    .busy     (busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Record every pulse with the index of the edge that produced it.
  always @(negedge clk) begin
    if (valid) begin
      rx_q.push_back(data);
      rx_e.push_back(edge_cnt);
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (valid2) begin
      rx2_q.push_back(data2);
      rx2_e.push_back(edge_cnt);
    end
    if (frame_err2) fe2_cnt = fe2_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_line = v;
    else rx_line2 = v;
  endtask

  // Drive the first nslots of a 10-slot frame (start, 8 data LSB first, stop); caller sits at a negedge.
  task automatic send_frame(input int which, input logic [7:0] b, input logic stop_bit,
                            input int cpb, input int nslots, output int e0);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    e0 = edge_cnt + 1;
    for (int i = 0; i < nslots; i++) begin
      set_line(which, frame[i]);
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic clear_logs();
    rx_q.delete();
    rx_e.delete();
    rx2_q.delete();
    rx2_e.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback_a5();
    int e0;
    int fe0;
    clear_logs();
    fe0 = fe_cnt;
    send_frame(0, 8'hA5, 1'b1, 10, 10, e0);
    repeat (5) @(negedge clk);
    total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL a5_count got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      total++; if (rx_q[0] !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h exp=a5", rx_q[0]); end
      total++; if (rx_e[0] - e0 !== 97) begin bad++; $display("FAIL a5_latency got=%0d exp=97", rx_e[0] - e0); end
    end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL a5_frame_err got=%0d exp=0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int e0;
    int fe0;
    clear_logs();
    fe0 = fe_cnt;
    exp_q = '{8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
    end
    foreach (exp_q[i]) send_frame(0, exp_q[i], 1'b1, 10, 10, e0);
    repeat (5) @(negedge clk);
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL b2b_frame_err got=%0d exp=0", fe_cnt - fe0); end
  endtask

  task automatic test_glitch();
    int fe0;
    int n;
    clear_logs();
    fe0 = fe_cnt;
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=%b exp=1", busy); end
    rx_line = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 7) begin
      @(negedge clk);
      n++;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_release got=%b exp=0 after %0d cycles", busy, n); end
    repeat (20) @(negedge clk);
    total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", rx_q.size()); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err_break();
    logic [7:0] prev;
    int e0;
    int fe0;
    clear_logs();
    prev = data;
    fe0 = fe_cnt;
    send_frame(0, 8'h3C, 1'b0, 10, 10, e0);
    repeat (50) @(negedge clk);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt - fe0); end
    total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL ferr_valid got=%0d exp=0", rx_q.size()); end
    total++; if (data !== prev) begin bad++; $display("FAIL ferr_data_held got=%h exp=%h", data, prev); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_break_busy got=%b exp=1", busy); end
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_rearm_busy got=%b exp=0", busy); end
    send_frame(0, 8'h81, 1'b1, 10, 10, e0);
    repeat (5) @(negedge clk);
    total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL ferr_next_count got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      total++; if (rx_q[0] !== 8'h81) begin bad++; $display("FAIL ferr_next_data got=%h exp=81", rx_q[0]); end
    end
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL ferr_total got=%0d exp=1", fe_cnt - fe0); end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    int fe0;
    clear_logs();
    fe0 = fe_cnt;
    send_frame(0, 8'hC3, 1'b1, 10, 5, e0);
    rx_line = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    rx_line = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h exp=00", data); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(0, 8'h11, 1'b1, 10, 10, e0);
    repeat (5) @(negedge clk);
    total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL midrst_count got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      total++; if (rx_q[0] !== 8'h11) begin bad++; $display("FAIL midrst_next_data got=%h exp=11", rx_q[0]); end
    end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL midrst_frame_err got=%0d exp=0", fe_cnt - fe0); end
  endtask

  task automatic test_fast_clock();
    int e0;
    clear_logs();
    send_frame(1, 8'hA5, 1'b1, 20, 10, e0);
    repeat (5) @(negedge clk);
    total++; if (rx2_q.size() !== 1) begin bad++; $display("FAIL fast_count got=%0d exp=1", rx2_q.size()); end
    if (rx2_q.size() > 0) begin
      total++; if (rx2_q[0] !== 8'hA5) begin bad++; $display("FAIL fast_data got=%h exp=a5", rx2_q[0]); end
      total++; if (rx2_e[0] - e0 !== 192) begin bad++; $display("FAIL fast_latency got=%0d exp=192", rx2_e[0] - e0); end
    end
    total++; if (fe2_cnt !== 0) begin bad++; $display("FAIL fast_frame_err got=%0d exp=0", fe2_cnt); end
  endtask

  // Random good and bad frames; model: good stop bit yields the byte, bad one yields a frame error.
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] exp_last;
    logic [7:0] b;
    logic       good;
    int         exp_fe;
    int         e0;
    int         fe0;
    clear_logs();
    fe0 = fe_cnt;
    exp_fe = 0;
    exp_last = data;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(0, b, good, 10, 10, e0);
      if (good) begin
        exp_q.push_back(b);
        exp_last = b;
      end else begin
        exp_fe++;
        repeat ($urandom_range(0, 30)) @(negedge clk);
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    total++; if (fe_cnt - fe0 !== exp_fe) begin bad++; $display("FAIL rand_frame_err got=%0d exp=%0d", fe_cnt - fe0, exp_fe); end
    total++; if (data !== exp_last) begin bad++; $display("FAIL rand_last_data got=%h exp=%h", data, exp_last); end
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_back_to_back();
    test_glitch();
    test_frame_err_break();
    test_reset_mid_frame();
    test_fast_clock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
